// File: rtl/branch_ctrl_unit.sv
// Fetch/decode/branch sequencer of the multicycle control unit.
// Non-branch opcodes are handed to the main execute FSM.
module branch_ctrl_unit #(
   parameter int         MEM_WAIT = 1,
   parameter logic [5:0] OP_BEQ   = 6'h04
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       exec_done,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] branch_ctrl,
   output logic       MemRead,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ALUOutWrite,
   output logic [1:0] PCSource,
   output logic       exec_req,
   output logic [2:0] state_out
);

   localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_BRANCH = 3'd3,
      S_EXEC   = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    br_sel;
   logic [5:0]    op_off;
   logic          is_branch;
   logic          last;

   // Offset from beq: the four branches occupy offsets 0..3.
   assign op_off    = opcode - OP_BEQ;
   assign is_branch = (op_off[5:2] == 4'd0);
   assign last      = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_RESET;
         cnt    <= '0;
         br_sel <= 2'b00;
      end else begin
         unique case (state)
            S_RESET: begin
               state <= S_FETCH;
               cnt   <= CW'(MEM_WAIT);
            end
            S_FETCH: begin
               if (last) state <= S_DECODE;
               else      cnt   <= cnt - CW'(1);
            end
            S_DECODE: begin
               br_sel <= op_off[1:0];
               state  <= is_branch ? S_BRANCH : S_EXEC;
            end
            S_BRANCH: begin
               state <= S_FETCH;
               cnt   <= CW'(MEM_WAIT);
            end
            S_EXEC: begin
               if (exec_done) begin
                  state <= S_FETCH;
                  cnt   <= CW'(MEM_WAIT);
               end
            end
            default: state <= S_RESET;
         endcase
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      branch_ctrl = 2'b00;
      MemRead     = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 3'b000;
      ALUOutWrite = 1'b0;
      PCSource    = 2'b00;
      exec_req    = 1'b0;
      unique case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            ALUOp   = 3'b001;
            PCWrite = last;
            IRWrite = last;
         end
         S_DECODE: begin
            ALUSrcB     = 2'b11;
            ALUOp       = 3'b001;
            ALUOutWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 3'b010;
            PCSource    = 2'b01;
            PCWriteCond = 1'b1;
            branch_ctrl = br_sel;
         end
         S_EXEC:  exec_req = 1'b1;
         default: ;
      endcase
   end

   assign state_out = state;

endmodule
